// File: rtl/basic_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// basic_cpu_sequencer
//   Control sequencer for the 16-bit accumulator CPU. Steps each instruction
//   through fetch -> decode -> (indirect) -> execute and drives the register
//   strobes, common-bus select, ALU op and memory handshake.
//
//   The START_PC clear value belongs to the PC register itself; this block
//   only requests it through pc_clr.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (0 = reset)
//   ir        IR output: [15]=I, [14:12]=opcode, [ADDR_W-1:0]=address/function
//   ac_zero   AC == 0
//   ac_neg    AC[15]
//   dr_zero   DR == 0 after DR increment
//   mem_ack   memory completes the pending mem_rd/mem_wr this cycle
//   mem_rd    memory read request, held until mem_ack
//   mem_wr    memory write request (data = bus), held until mem_ack
//   bus_sel   0 none,1 AR,2 PC,3 DR,4 AC,5 IR,6 TR,7 MEM
//   alu_op    0 hold,1 AND,2 ADD,3 LOAD(DR),4 CMA,5 CLA,6 INC
//   ar_ld pc_ld pc_inr pc_clr ir_ld dr_ld dr_inr ac_ld tr_ld
//             one-cycle register strobes
//   halted    sequencer stopped in HALT
//   state     current state (debug): 0 RESET,1 F0,2 F1,3 DEC,4 IND,
//             5 EX0,6 EX1,7 EX2,8 RREF,9 HALT
// -----------------------------------------------------------------------------
module basic_cpu_sequencer #(
   parameter int ADDR_W = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        ac_zero,
   input  logic        ac_neg,
   input  logic        dr_zero,
   input  logic        mem_ack,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [2:0]  bus_sel,
   output logic [2:0]  alu_op,
   output logic        ar_ld,
   output logic        pc_ld,
   output logic        pc_inr,
   output logic        pc_clr,
   output logic        ir_ld,
   output logic        dr_ld,
   output logic        dr_inr,
   output logic        ac_ld,
   output logic        tr_ld,
   output logic        halted,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_RESET = 4'd0,
      S_F0    = 4'd1,
      S_F1    = 4'd2,
      S_DEC   = 4'd3,
      S_IND   = 4'd4,
      S_EX0   = 4'd5,
      S_EX1   = 4'd6,
      S_EX2   = 4'd7,
      S_RREF  = 4'd8,
      S_HALT  = 4'd9
   } state_e;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_ADD  = 3'd1,
      OP_LDA  = 3'd2,
      OP_STA  = 3'd3,
      OP_BUN  = 3'd4,
      OP_BSA  = 3'd5,
      OP_ISZ  = 3'd6,
      OP_RREF = 3'd7
   } op_e;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   localparam logic [2:0] ALU_HOLD = 3'd0;
   localparam logic [2:0] ALU_AND  = 3'd1;
   localparam logic [2:0] ALU_ADD  = 3'd2;
   localparam logic [2:0] ALU_LOAD = 3'd3;
   localparam logic [2:0] ALU_CMA  = 3'd4;
   localparam logic [2:0] ALU_CLA  = 3'd5;
   localparam logic [2:0] ALU_INC  = 3'd6;

   localparam int IDX_W = $clog2(ADDR_W);

   state_e             state_q, state_d;
   op_e                op_q;
   logic               i_q;
   logic [ADDR_W-1:0]  fn;
   logic [IDX_W-1:0]   fn_hi;
   logic               fn_any;

   // I and opcode are captured in DEC so execute does not depend on IR
   // staying stable afterwards.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_RESET;
         op_q    <= OP_AND;
         i_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DEC) begin
            op_q <= op_e'(ir[14:12]);
            i_q  <= ir[15];
         end
      end
   end

   // Register-reference priority: highest set function bit wins. The
   // ascending loop lets the last (highest) match overwrite earlier ones.
   assign fn = ir[ADDR_W-1:0];

   always_comb begin
      fn_hi  = '0;
      fn_any = 1'b0;
      for (int b = 0; b < ADDR_W; b++) begin
         if (fn[b]) begin
            fn_hi  = IDX_W'(b);
            fn_any = 1'b1;
         end
      end
   end

   // NOTE: every output and the next state get a default first, so no path
   // through the case statement can leave a value unassigned (no latches).
   always_comb begin
      state_d = state_q;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      bus_sel = BUS_NONE;
      alu_op  = ALU_HOLD;
      ar_ld   = 1'b0;
      pc_ld   = 1'b0;
      pc_inr  = 1'b0;
      pc_clr  = 1'b0;
      ir_ld   = 1'b0;
      dr_ld   = 1'b0;
      dr_inr  = 1'b0;
      ac_ld   = 1'b0;
      tr_ld   = 1'b0;
      halted  = 1'b0;

      unique case (state_q)
         S_RESET: begin
            // The state register is held here while rst is low; gating with
            // rst keeps pc_clr quiet during reset and raises it only in the
            // cycle after release.
            pc_clr  = rst;
            state_d = S_F0;
         end

         S_F0: begin
            bus_sel = BUS_PC;
            ar_ld   = 1'b1;
            state_d = S_F1;
         end

         S_F1: begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            if (mem_ack) begin
               ir_ld   = 1'b1;
               pc_inr  = 1'b1;
               state_d = S_DEC;
            end
         end

         S_DEC: begin
            bus_sel = BUS_IR;
            ar_ld   = 1'b1;
            if (ir[14:12] == OP_RREF) state_d = S_RREF;
            else if (ir[15])          state_d = S_IND;
            else                      state_d = S_EX0;
         end

         S_IND: begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            if (mem_ack) begin
               ar_ld   = 1'b1;
               state_d = S_EX0;
            end
         end

         S_EX0: begin
            unique case (op_q)
               OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                  mem_rd  = 1'b1;
                  bus_sel = BUS_MEM;
                  if (mem_ack) begin
                     dr_ld   = 1'b1;
                     state_d = S_EX1;
                  end
               end
               OP_STA: begin
                  mem_wr  = 1'b1;
                  bus_sel = BUS_AC;
                  if (mem_ack) state_d = S_F0;
               end
               OP_BUN: begin
                  bus_sel = BUS_AR;
                  pc_ld   = 1'b1;
                  state_d = S_F0;
               end
               OP_BSA: begin
                  // Return address goes to M[AR]; PC becomes AR+1 below.
                  mem_wr  = 1'b1;
                  bus_sel = BUS_PC;
                  if (mem_ack) state_d = S_EX1;
               end
               default: state_d = S_F0;
            endcase
         end

         S_EX1: begin
            unique case (op_q)
               OP_AND: begin alu_op = ALU_AND;  ac_ld = 1'b1; state_d = S_F0; end
               OP_ADD: begin alu_op = ALU_ADD;  ac_ld = 1'b1; state_d = S_F0; end
               OP_LDA: begin alu_op = ALU_LOAD; ac_ld = 1'b1; state_d = S_F0; end
               OP_BSA: begin
                  bus_sel = BUS_AR;
                  pc_ld   = 1'b1;
                  state_d = S_EX2;
               end
               OP_ISZ: begin
                  dr_inr  = 1'b1;
                  state_d = S_EX2;
               end
               default: state_d = S_F0;
            endcase
         end

         S_EX2: begin
            unique case (op_q)
               OP_BSA: begin
                  pc_inr  = 1'b1;
                  state_d = S_F0;
               end
               OP_ISZ: begin
                  mem_wr  = 1'b1;
                  bus_sel = BUS_DR;
                  if (mem_ack) begin
                     pc_inr  = dr_zero;
                     state_d = S_F0;
                  end
               end
               default: state_d = S_F0;
            endcase
         end

         S_RREF: begin
            state_d = S_F0;
            // I=1 is the I/O group, treated as NOP.
            if (!i_q && fn_any) begin
               case (int'(fn_hi))
                  11: begin alu_op = ALU_CLA; ac_ld = 1'b1; end
                  9:  begin alu_op = ALU_CMA; ac_ld = 1'b1; end
                  5:  begin alu_op = ALU_INC; ac_ld = 1'b1; end
                  4:  pc_inr = !ac_neg;
                  3:  pc_inr = ac_neg;
                  2:  pc_inr = ac_zero;
                  0:  state_d = S_HALT;
                  default: ;
               endcase
            end
         end

         S_HALT: halted = 1'b1;

         default: state_d = S_RESET;
      endcase
   end

   assign state = state_q;

endmodule
